mini_mips_multicycle: RTL and testbench
=======================================

// Module: mini_mips_multicycle
// PURPOSE
//  Parametrised multicycle successor of the single-cycle MiniMIPS core; same 16-bit ISA encoding.
//  Encoding: op[15:12] rs[11:9] rt[8:6] rd[5:3] funct[2:0] imm[5:0].
//  FSM-sequenced datapath; one ALU and one register file shared across states.
//  Instruction and data memories are external, reached over req/ready handshakes, so wait-state memories are supported.
// PARAMETERS
//  DATA_W   32  datapath, register and data-address width (>=8, power of 2)
//  REG_CNT  8   register count; index = low $clog2(REG_CNT) bits of rs/rt/rd fields (max 8)
//  PC_W     16  PC / instruction-address width; word-addressed, +1 per instruction
// PORTS
//  clock        in   1       rising-edge clock
//  reset_n      in   1       asynchronous, active-low reset
//  imem_req     out  1       instruction fetch request
//  imem_addr    out  PC_W    fetch address (= pc)
//  imem_ready   in   1       fetch complete; imem_rdata valid
//  imem_rdata   in   16      instruction word
//  dmem_req     out  1       data access request
//  dmem_we      out  1       1=store, 0=load; valid while dmem_req
//  dmem_addr    out  DATA_W  ALU result (rs + sext(imm))
//  dmem_wdata   out  DATA_W  rt value (stores)
//  dmem_ready   in   1       access complete; dmem_rdata valid for loads
//  dmem_rdata   in   DATA_W  load data
//  pc           out  PC_W    current PC
//  halted       out  1       core stopped on HALT
//  perf_cycles  out  32      cycle counter (see CONFIGURATION)
//  perf_instret out  32      retired-instruction counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, reset_n low): state=IDLE, pc=0, all registers=0, A/B/IR latches=0.
//  Outputs during reset: imem_req=0, dmem_req=0, dmem_we=0, halted=0.
//  States: IDLE->FETCH unconditionally.
//   FETCH: imem_req=1 and imem_addr=pc held stable until imem_ready sampled high; then IR<=imem_rdata, go DECODE.
//   DECODE: A<=R[rs], B<=R[rt]. HALT(1111) -> HALT state. Otherwise -> EXEC.
//   EXEC: ALU op.
//    R-type and immediate ops -> WB.
//    LW/SW -> MEM.
//    BEQ/BNE -> FETCH with pc<=pc+1+sext(imm) if taken, else pc+1.
//   MEM: dmem_req=1; addr/we/wdata held stable until dmem_ready high.
//    LW -> WB (data latched on the dmem_ready edge). SW -> FETCH, pc+1.
//   WB: R[dest]<=result; pc<=pc+1; -> FETCH.
//   HALT: terminal until reset; halted=1, both reqs 0, pc frozen.
//  Ready sampled only while the matching req is high. Ready in the same cycle as req completes the access (zero-wait).
//  Opcodes:
//   0000 R-type, dest=rd, funct: 000 add, 001 sub, 010 and, 011 or, 100 slt (signed), 101 xor, 110 sll, 111 srl.
//   0001 addi, 0010 andi, 0011 ori, 0100 slti; dest=rt.
//   0101 lw, 0110 sw, 0111 beq, 1000 bne, 1111 halt.
//   1001-1110 = NOP: pc+1, no write, FETCH after EXEC.
//  Arithmetic: imm always sign-extended to DATA_W. add/sub wrap mod 2^DATA_W.
//   Shift amount = B[$clog2(DATA_W)-1:0]. slt/slti result = 0 or 1.
//  PC arithmetic wraps mod 2^PC_W.
//  R0 reads as 0; writes to R0 are discarded.
//  Zero-wait latency: R/imm/lw = 4/4/5 cycles; sw 4; branch/NOP 3.
//  Reset mid-handshake: reqs drop asynchronously; in-flight access is abandoned; restart at pc=0.
// CONFIGURATION
//  MINI_MIPS_PERF_EN defined:
//   perf_cycles increments every clock after reset except in HALT.
//   perf_instret increments once per retired instruction (WB, SW completion, branch/NOP, HALT entry).
//   Both counters wrap at 2^32 and reset to 0.
//  MINI_MIPS_PERF_EN undefined: both outputs tied to 0; no counter flops.
// TESTING
//  1 reset_n low mid-FETCH with imem_req=1 -> imem_req=0 immediately; after release: IDLE, then FETCH with imem_addr=0.
//  2 zero-wait program 0x1045 (addi r1,r0,5), 0x10BD (addi r2,r0,-3), 0x0298 (add r3,r1,r2) -> r3=2; add retires 4 cycles after its fetch.
//  3 sw r1 to addr 8, then lw r4 from 8; dmem_ready delayed 3 cycles -> dmem_req/addr=8/wdata=5 stable 4 cycles; r4=5.
//  4 beq r1,r1,imm=-1 at pc=10 -> next fetch pc=10. bne r1,r1 -> pc=11.
//  5 addi r0,r0,7 then add r5,r0,r0 -> r5=0. Then 0xF000 -> halted=1, imem_req stays 0, pc frozen.
//  6 MINI_MIPS_PERF_EN: test 2 + halt, zero-wait -> perf_instret=4. Undefined -> both counters read 0.

Source files
------------

// File: rtl/mini_mips_multicycle.sv
// Multicycle MiniMIPS core: 16-bit ISA, shared ALU/register file, req/ready instruction and data ports.
// Define MINI_MIPS_PERF_EN to build the cycle / retired-instruction counters; otherwise both read 0.
module mini_mips_multicycle #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_CNT = 8,
  parameter int unsigned PC_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_instret
);
  localparam int unsigned RIW = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;
  localparam int unsigned SHW = $clog2(DATA_W);

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_ANDI = 4'h2;
  localparam logic [3:0] OP_ORI  = 4'h3;
  localparam logic [3:0] OP_SLTI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_BNE  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  state_e                         state_q, state_d;
  logic [PC_W-1:0]                pc_q, pc_d;
  logic [15:0]                    ir_q, ir_d;
  logic [DATA_W-1:0]              a_q, a_d, b_q, b_d, res_q, res_d;
  logic [REG_CNT-1:0][DATA_W-1:0] regs_q, regs_d;
  logic                           imem_req_q, imem_req_d;
  logic                           dmem_req_q, dmem_req_d;
  logic                           dmem_we_q, dmem_we_d;
  logic                           halted_q, halted_d;

  logic [3:0]        op;
  logic [2:0]        funct, fn;
  logic [RIW-1:0]    rs_idx, rt_idx, rd_idx, dest_idx;
  logic [DATA_W-1:0] imm_ext, alu_b, alu_y;
  logic [PC_W-1:0]   pc_inc, pc_br;
  logic              lt;

  assign op       = ir_q[15:12];
  assign funct    = ir_q[2:0];
  assign rs_idx   = ir_q[9 +: RIW];
  assign rt_idx   = ir_q[6 +: RIW];
  assign rd_idx   = ir_q[3 +: RIW];
  assign dest_idx = (op == OP_R) ? rd_idx : rt_idx;
  assign imm_ext  = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
  assign pc_inc   = pc_q + PC_W'(1);
  assign pc_br    = pc_inc + {{(PC_W-6){ir_q[5]}}, ir_q[5:0]};

  // Immediate ops reuse the R-type funct encoding for the shared ALU.
  always_comb begin
    fn = 3'd0;
    case (op)
      OP_R:    fn = funct;
      OP_ANDI: fn = 3'd2;
      OP_ORI:  fn = 3'd3;
      OP_SLTI: fn = 3'd4;
      default: fn = 3'd0;
    endcase
  end

  always_comb begin
    alu_b = (op == OP_R) ? b_q : imm_ext;
    lt    = $signed(a_q) < $signed(alu_b);
    alu_y = '0;
    case (fn)
      3'd0:    alu_y = a_q + alu_b;
      3'd1:    alu_y = a_q - alu_b;
      3'd2:    alu_y = a_q & alu_b;
      3'd3:    alu_y = a_q | alu_b;
      3'd4:    alu_y = {{(DATA_W-1){1'b0}}, lt};
      3'd5:    alu_y = a_q ^ alu_b;
      3'd6:    alu_y = a_q << alu_b[SHW-1:0];
      default: alu_y = a_q >> alu_b[SHW-1:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    regs_d   = regs_q;
    halted_d = halted_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_req_q && imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = (rs_idx == '0) ? '0 : regs_q[rs_idx];
        b_d = (rt_idx == '0) ? '0 : regs_q[rt_idx];
        if (op == OP_HALT) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = alu_y;
        state_d = S_FETCH;
        case (op)
          OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_WB;
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BEQ:  pc_d = (a_q == b_q) ? pc_br : pc_inc;
          OP_BNE:  pc_d = (a_q != b_q) ? pc_br : pc_inc;
          default: pc_d = pc_inc;
        endcase
      end
      S_MEM: begin
        if (dmem_req_q && dmem_ready) begin
          if (op == OP_LW) begin
            res_d   = dmem_rdata;
            state_d = S_WB;
          end else begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        if (dest_idx != '0) regs_d[dest_idx] = res_q;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // Request strobes are registered from the state being entered.
    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
    dmem_we_d  = (state_d == S_MEM) && (op == OP_SW);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      regs_q     <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      regs_q     <= regs_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = res_q;
  assign dmem_wdata = b_q;
  assign pc         = pc_q;
  assign halted     = halted_q;

`ifdef MINI_MIPS_PERF_EN
  logic [31:0] cyc_q, cyc_d, ret_q, ret_d;
  logic        retire;

  // An instruction retires when its last state hands back to FETCH, or on HALT entry.
  always_comb begin
    retire = ((state_d == S_FETCH) &&
              ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB))) ||
             ((state_q == S_DECODE) && (state_d == S_HALT));
    cyc_d  = (state_q != S_HALT) ? cyc_q + 32'd1 : cyc_q;
    ret_d  = retire ? ret_q + 32'd1 : ret_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign perf_cycles  = cyc_q;
  assign perf_instret = ret_q;
`else
  assign perf_cycles  = '0;
  assign perf_instret = '0;
`endif
endmodule

// File: tb/tb_mini_mips_multicycle.sv
// Directed bench for mini_mips_multicycle: behavioural memories with programmable wait states
// and a store scoreboard filled when each program is loaded.
module tb_mini_mips_multicycle;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 16;
`ifdef MINI_MIPS_PERF_EN
  localparam int unsigned EXP_CYC = 15;
  localparam int unsigned EXP_RET = 4;
`else
  localparam int unsigned EXP_CYC = 0;
  localparam int unsigned EXP_RET = 0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ready = 1'b0;
  logic [15:0]       imem_rdata = 16'h0;
  logic              dmem_req, dmem_we;
  logic [DATA_W-1:0] dmem_addr, dmem_wdata;
  logic              dmem_ready = 1'b0;
  logic [DATA_W-1:0] dmem_rdata = '0;
  logic [PC_W-1:0]   pc;
  logic              halted;
  logic [31:0]       perf_cycles, perf_instret;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  st_t         exp_q[$];
  st_t         e;
  int          flog_a[$];
  int          fcyc[$];
  logic [15:0] imem[0:255];
  logic [31:0] dmem[0:255];
  int          imem_lat = 0, dmem_lat = 0, icnt = 0, dcnt = 0;
  int          cyc = 0, n_st = 0;
  int          n_pass = 0, n_fail = 0, n_total = 0;
  logic [31:0] d_addr0, d_wdata0;
  logic        d_we0, d_stable;

  mini_mips_multicycle dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc(pc), .halted(halted), .perf_cycles(perf_cycles), .perf_instret(perf_instret)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int fc(input int i);
    return (i < fcyc.size()) ? fcyc[i] : -1000;
  endfunction

  function automatic int fa(input int i);
    return (i < flog_a.size()) ? flog_a[i] : -1;
  endfunction

  // Instruction memory: responds imem_lat cycles after the request is first seen.
  always @(negedge clock) begin
    if (imem_req) begin
      if (icnt == 0) begin
        flog_a.push_back(int'(imem_addr));
        fcyc.push_back(cyc);
      end
      if (icnt >= imem_lat) begin
        imem_ready = 1'b1;
        imem_rdata = imem[imem_addr[7:0]];
        icnt = 0;
      end else begin
        imem_ready = 1'b0;
        icnt++;
      end
    end else begin
      imem_ready = 1'b0;
      icnt = 0;
    end
  end

  // Data memory: tracks request stability and scores each completed store.
  always @(negedge clock) begin
    if (dmem_req) begin
      if (dcnt == 0) begin
        d_addr0  = dmem_addr;
        d_wdata0 = dmem_wdata;
        d_we0    = dmem_we;
        d_stable = 1'b1;
      end else if (dmem_addr !== d_addr0 || dmem_we !== d_we0 ||
                   (dmem_we && dmem_wdata !== d_wdata0)) begin
        d_stable = 1'b0;
      end
      if (dcnt >= dmem_lat) begin
        dmem_ready = 1'b1;
        if (dmem_we) begin
          dmem[dmem_addr[7:0]] = dmem_wdata;
          n_st++;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("st_addr", 64'(dmem_addr), 64'(e.addr));
            check("st_data", 64'(dmem_wdata), 64'(e.data));
            check("st_stable", 64'(d_stable), 64'(1));
          end
        end else begin
          dmem_rdata = dmem[dmem_addr[7:0]];
        end
        dcnt = 0;
      end else begin
        dmem_ready = 1'b0;
        dcnt++;
      end
    end else begin
      dmem_ready = 1'b0;
      dcnt = 0;
    end
  end

  task automatic start_phase();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    flog_a.delete();
    fcyc.delete();
    exp_q.delete();
    n_st = 0;
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'h9000;
      dmem[i] = '0;
    end
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic run_until_halt(input int max_cyc);
    int n = 0;
    while (!halted && n < max_cyc) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("halt_reached", 64'(halted), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prog[$];

    // Reset values, then reset asserted mid-FETCH.
    start_phase();
    imem_lat = 5;
    #3;
    check("rst_imem_req", 64'(imem_req), 64'(0));
    check("rst_dmem_req", 64'(dmem_req), 64'(0));
    check("rst_dmem_we", 64'(dmem_we), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
    check("rst_pc", 64'(pc), 64'(0));
    check("rst_perf_cyc", 64'(perf_cycles), 64'(0));
    release_reset();
    #1 check("idle_req", 64'(imem_req), 64'(0));
    @(posedge clock); #1;
    check("fetch_req", 64'(imem_req), 64'(1));
    check("fetch_addr", 64'(imem_addr), 64'(0));
    @(posedge clock); @(posedge clock); #2;
    check("fetch_held", 64'(imem_req), 64'(1));
    reset_n = 1'b0;
    #1 check("async_drop", 64'(imem_req), 64'(0));
    release_reset();
    #1 check("idle_after_rst", 64'(imem_req), 64'(0));
    @(posedge clock); #1;
    check("refetch_req", 64'(imem_req), 64'(1));
    check("refetch_addr", 64'(imem_addr), 64'(0));

    // Zero-wait arithmetic + halt: latency and performance counters.
    start_phase();
    imem_lat = 0;
    dmem_lat = 0;
    prog = '{16'h1045, 16'h10BD, 16'h0298, 16'hF000};
    foreach (prog[i]) imem[i] = prog[i];
    release_reset();
    run_until_halt(200);
    repeat (3) @(posedge clock);
    #1;
    check("b_nfetch", 64'(flog_a.size()), 64'(4));
    check("b_addi_lat", 64'(fc(1) - fc(0)), 64'(4));
    check("b_add_lat", 64'(fc(3) - fc(2)), 64'(4));
    check("b_halt_pc", 64'(pc), 64'(3));
    check("b_perf_cyc", 64'(perf_cycles), 64'(EXP_CYC));
    check("b_perf_ret", 64'(perf_instret), 64'(EXP_RET));

    // Full program with 3-wait data memory; results observed via stores.
    start_phase();
    dmem_lat = 3;
    prog = '{16'h1045, 16'h10BD, 16'h0298, 16'h60C0, 16'h6048, 16'h5108, 16'h6109, 16'h1007,
             16'h0028, 16'h614A, 16'h02B1, 16'h618B, 16'h047C, 16'h61CC, 16'h0276, 16'h618D,
             16'h047F, 16'h61CE, 16'h02B5, 16'h618F, 16'h43FF, 16'h61D0, 16'h8245, 16'h7285,
             16'h7242, 16'h6054, 16'h6054, 16'h9000, 16'h6091, 16'hF000};
    foreach (prog[i]) imem[i] = prog[i];
    push_st(32'd0, 32'd2);
    push_st(32'd8, 32'd5);
    push_st(32'd9, 32'd5);
    push_st(32'd10, 32'd0);
    push_st(32'd11, 32'd8);
    push_st(32'd12, 32'd1);
    push_st(32'd13, 32'd160);
    push_st(32'd14, 32'h07FF_FFFF);
    push_st(32'd15, 32'hFFFF_FFF8);
    push_st(32'd16, 32'd0);
    push_st(32'd17, 32'hFFFF_FFFD);
    release_reset();
    run_until_halt(2000);
    check("c_nstores", 64'(n_st), 64'(11));
    check("c_exp_left", 64'(exp_q.size()), 64'(0));
    check("c_nfetch", 64'(flog_a.size()), 64'(28));
    check("c_add_lat", 64'(fc(3) - fc(2)), 64'(4));
    check("c_sw_lat", 64'(fc(4) - fc(3)), 64'(7));
    check("c_lw_lat", 64'(fc(6) - fc(5)), 64'(8));
    check("c_bne_nt_lat", 64'(fc(23) - fc(22)), 64'(3));
    check("c_beq_nt_pc", 64'(fa(24)), 64'(24));
    check("c_beq_t_pc", 64'(fa(25)), 64'(27));
    check("c_beq_t_lat", 64'(fc(25) - fc(24)), 64'(3));
    check("c_nop_lat", 64'(fc(26) - fc(25)), 64'(3));
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("c_halt_ireq", 64'(imem_req), 64'(0));
      check("c_halt_pc", 64'(pc), 64'(29));
      check("c_halted", 64'(halted), 64'(1));
    end

    // Taken branch to itself, then not-taken bne at the same pc.
    start_phase();
    dmem_lat = 0;
    imem[10] = 16'h727F;
    release_reset();
    for (int n = 0; n < 200 && flog_a.size() < 13; n++) begin
      @(posedge clock); #1;
    end
    check("d_nop_pc", 64'(fa(10)), 64'(10));
    check("d_beq_pc1", 64'(fa(11)), 64'(10));
    check("d_beq_pc2", 64'(fa(12)), 64'(10));
    check("d_beq_lat", 64'(fc(11) - fc(10)), 64'(3));
    start_phase();
    imem[10] = 16'h827F;
    imem[11] = 16'hF000;
    release_reset();
    run_until_halt(200);
    check("d_bne_pc", 64'(fa(11)), 64'(11));
    check("d_bne_halt_pc", 64'(pc), 64'(11));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
